req_arbiter4: RTL and testbench

Four-requester bus arbiter built around a 4-to-2 priority encoder. It samples four request lines, grants exactly one requester at a time, and holds the grant until the owner releases it, signals done, or exceeds a hold limit. It supports fixed priority (index 3 highest) or round-robin rotation. It sits in front of any shared resource the priority encoder currently selects statically, such as a shared bus, a memory port or a UART transmitter.

---
 rtl/arb_pkg.sv | 15 +
 rtl/prio_enc4.sv | 15 +
 rtl/req_arbiter4.sv | 88 ++++++++
 tb/tb_req_arbiter4.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester arbiter.
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/prio_enc4.sv
// 4-to-2 priority encoder; the highest set bit wins.
module prio_enc4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  output logic [IDW-1:0]     idx,
  output logic               vld
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req[i]) idx = IDW'(i);
    vld = |req;
  end
endmodule

// File: rtl/req_arbiter4.sv
// Four-requester arbiter: fixed or rotating priority, grant held until
// release, done, or the hold limit expires; one idle cycle between owners.
module req_arbiter4
  import arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int HOLD_MAX    = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               busy,
  output logic               timeout
);
  localparam logic [7:0] HOLD_LIM = 8'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  arb_state_t         state;
  logic [7:0]         cnt;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ofs;
  logic [NUM_REQ-1:0] rot;
  logic [IDW-1:0]     enc_idx;
  logic               enc_vld;
  logic [IDW-1:0]     win;
  logic               hold_hit;
  logic               release_now;

  // Rotating by the last owner puts ptr-1 at the top and ptr itself at the bottom.
  assign ofs = (ROUND_ROBIN != 0) ? ptr : '0;

  always_comb begin
    rot = '0;
    for (int k = 0; k < NUM_REQ; k++)
      rot[k] = req[IDW'(ofs + IDW'(k))];
  end

  prio_enc4 u_enc (
    .req (rot),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  assign win         = enc_idx + ofs;
  assign hold_hit    = (HOLD_MAX != 0) && (cnt == HOLD_LIM);
  assign release_now = hold_hit || !req[gnt_id] || done;
  assign busy        = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (enc_vld) begin
            gnt    <= onehot(win);
            gnt_id <= win;
            cnt    <= '0;
            state  <= GRANT;
            if (ROUND_ROBIN != 0) ptr <= win;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          cnt <= cnt + 8'(cnt != 8'hFF);
          if (release_now) begin
            gnt     <= '0;
            state   <= GAP;
            timeout <= hold_hit;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_req_arbiter4.sv
// Directed checks of req_arbiter4 in fixed, round-robin and short-hold builds.
module tb_req_arbiter4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       done = 1'b0;

  logic [3:0] gnt_f, gnt_r, gnt_t;
  logic [1:0] id_f, id_r, id_t;
  logic       busy_f, busy_r, busy_t;
  logic       to_f, to_r, to_t;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  req_arbiter4 #(.ROUND_ROBIN(0), .HOLD_MAX(15)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_f), .gnt_id(id_f), .busy(busy_f), .timeout(to_f));

  req_arbiter4 #(.ROUND_ROBIN(1), .HOLD_MAX(15)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_r), .gnt_id(id_r), .busy(busy_r), .timeout(to_r));

  req_arbiter4 #(.ROUND_ROBIN(1), .HOLD_MAX(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_t), .gnt_id(id_t), .busy(busy_t), .timeout(to_t));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0;
    done  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rr_exp [5] = '{3, 2, 1, 0, 3};
    logic [3:0] oh;

    do_reset();
    chk("rst_gnt", gnt_f, 4'b0000);
    chk("rst_busy", busy_r, 1'b0);
    chk("rst_to", to_t, 1'b0);
    chk("rst_id", id_r, 2'd0);

    // Fixed priority: 3 wins over 1, then 1 after one gap cycle.
    req = 4'b1010;
    step();
    chk("fix_gnt3", gnt_f, 4'b1000);
    chk("fix_id3", id_f, 2'd3);
    req = 4'b0010;
    step();
    chk("fix_gap", gnt_f, 4'b0000);
    chk("fix_gap_busy", busy_f, 1'b0);
    step();
    chk("fix_gnt1", gnt_f, 4'b0010);
    chk("fix_id1", id_f, 2'd1);

    // Round-robin rotation with every owner pulsing done on its second cycle.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << rr_exp[i];
      step();
      chk($sformatf("rr_gnt%0d", i), gnt_r, oh);
      chk($sformatf("rr_id%0d", i), id_r, rr_exp[i]);
      chk($sformatf("rr_fix%0d", i), gnt_f, 4'b1000);
      step();
      chk($sformatf("rr_hold%0d", i), gnt_r, oh);
      done = 1'b1;
      step();
      done = 1'b0;
      chk($sformatf("rr_gap%0d", i), gnt_r, 4'b0000);
      chk($sformatf("rr_gap_to%0d", i), to_r, 1'b0);
    end

    // Asynchronous reset mid-grant; pointer must return to 0.
    step();
    chk("pre_rst_rr", gnt_r, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt_r", gnt_r, 4'b0000);
    chk("arst_busy_f", busy_f, 1'b0);
    chk("arst_to_t", to_t, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", gnt_r, 4'b1000);
    chk("post_rst_id", id_r, 2'd3);

    // Hold limit of 4 cycles with req held.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("to_gnt%0d", i), gnt_t, 4'b0100);
      chk($sformatf("to_pulse%0d", i), to_t, 1'b0);
    end
    step();
    chk("to_gap_gnt", gnt_t, 4'b0000);
    chk("to_gap_pulse", to_t, 1'b1);
    step();
    chk("to_regnt", gnt_t, 4'b0100);
    chk("to_pulse_clr", to_t, 1'b0);
    step();
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("to_done_gnt", gnt_t, 4'b0000);
    chk("to_done_pulse", to_t, 1'b1);

    // done and owner drop together: one release, no pulse, one gap.
    do_reset();
    req = 4'b0001;
    step();
    chk("sim_gnt", gnt_f, 4'b0001);
    done = 1'b1;
    req  = 4'b0000;
    step();
    done = 1'b0;
    chk("sim_rel", gnt_f, 4'b0000);
    chk("sim_to", to_f, 1'b0);
    req = 4'b0001;
    step();
    chk("sim_regnt", gnt_f, 4'b0001);

    // done while idle is ignored.
    do_reset();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("idle_done", gnt_f, 4'b0000);
    req = 4'b0010;
    step();
    chk("idle_done_gnt", gnt_f, 4'b0010);
    step();
    chk("idle_done_hold", gnt_f, 4'b0010);

    // No requests: nothing ever granted.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step();
      chk($sformatf("noreq_busy%0d", i), {busy_f, busy_r, busy_t}, 3'b000);
    end
    req = 4'b0001;
    step();
    chk("noreq_then_gnt", gnt_r, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
